imm_decode_stage: RTL and testbench

Registered, parametrised successor to the combinational immediate extender. It decodes the immediate of a RISC-V instruction for any XLEN (32 or 64), adds the new Z (CSR uimm) and SHAMT formats, and computes the PC-relative target pc+imm. It sits between the fetch/decode handshake and execute, and is buffered by a 2-entry skid FIFO with valid/ready on both sides and a flush input.

---
 rtl/imm_decode_stage_if.sv | 31 +++
 rtl/imm_decode_stage.sv | 133 +++++++++++++
 tb/tb_imm_decode_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate decode stage: upstream beat in, decoded beat out.
// master drives beats in and accepts them out; slave is the stage itself.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_pc_rel;
  logic [XLEN-1:0]  out_pc;
  logic [TAG_W-1:0] out_tag;
  logic             out_imm_err;

  modport master (
    output in_valid, in_instr, in_imm_src, in_pc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_pc_rel, out_pc, out_tag, out_imm_err
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_pc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_pc_rel, out_pc, out_tag, out_imm_err
  );
endinterface

// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode with PC-relative target, buffered by a 2-entry skid FIFO.
// Decode and pc+imm are combinational on the input side; results are stored per entry.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_U     = 3'b000;
  localparam logic [2:0] FMT_I     = 3'b001;
  localparam logic [2:0] FMT_J     = 3'b010;
  localparam logic [2:0] FMT_S     = 3'b011;
  localparam logic [2:0] FMT_B     = 3'b100;
  localparam logic [2:0] FMT_Z     = 3'b101;
  localparam logic [2:0] FMT_SHAMT = 3'b110;

  // Every format fits in 32 bits; zero-extended formats keep bit 31 clear so
  // a single signed widening to XLEN serves all of them.
  function automatic logic signed [31:0] imm_word(input logic [31:0] instr,
                                                  input logic [2:0]  src);
    logic signed [31:0] r;
    r = '0;
    case (src)
      FMT_U:     r = {instr[31:12], 12'b0};
      FMT_I:     r = {{20{instr[31]}}, instr[31:20]};
      FMT_J:     r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      FMT_S:     r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_Z:     r = {27'b0, instr[19:15]};
      FMT_SHAMT: r = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic signed [XLEN-1:0] widen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic signed [XLEN-1:0] dec_imm;
  logic        [XLEN-1:0] dec_pc_rel;
  logic                   dec_err;

  assign dec_imm    = widen(imm_word(bus.in_instr, bus.in_imm_src));
  assign dec_err    = (bus.in_imm_src == 3'b111);
  assign dec_pc_rel = bus.in_pc + dec_imm;

  // ---- FIFO control ----
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       accept, pop;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign accept        = bus.in_valid  & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (pop)    rd_ptr_d = ~rd_ptr_q;
      case ({accept, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---- FIFO payload ----
  logic        [XLEN-1:0]  imm_q    [2];
  logic        [XLEN-1:0]  pc_rel_q [2];
  logic        [XLEN-1:0]  pc_q     [2];
  logic        [TAG_W-1:0] tag_q    [2];
  logic                    err_q    [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        imm_q[i]    <= '0;
        pc_rel_q[i] <= '0;
        pc_q[i]     <= '0;
        tag_q[i]    <= '0;
        err_q[i]    <= 1'b0;
      end
    end else if (accept && !flush) begin
      imm_q[wr_ptr_q]    <= dec_imm;
      pc_rel_q[wr_ptr_q] <= dec_pc_rel;
      pc_q[wr_ptr_q]     <= bus.in_pc;
      tag_q[wr_ptr_q]    <= bus.in_tag;
      err_q[wr_ptr_q]    <= dec_err;
    end
  end

  assign bus.out_imm     = imm_q[rd_ptr_q];
  assign bus.out_pc_rel  = pc_rel_q[rd_ptr_q];
  assign bus.out_pc      = pc_q[rd_ptr_q];
  assign bus.out_tag     = tag_q[rd_ptr_q];
  assign bus.out_imm_err = err_q[rd_ptr_q];

  // A stalled head must not change underneath the consumer.
  a_count_range : assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
  a_head_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready && !flush) |=>
      (bus.out_tag == $past(bus.out_tag) && bus.out_imm == $past(bus.out_imm)));

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_decode_stage;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .TAG_W(5)) bus32 ();
  imm_decode_stage_if #(.XLEN(64), .TAG_W(5)) bus64 ();

  imm_decode_stage #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
  imm_decode_stage #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc;
    logic [4:0]  tag;
    logic [31:0] imm32;
    logic [31:0] rel32;
    logic [63:0] imm64;
    logic [63:0] rel64;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                       input logic [63:0] pc, input logic [4:0] tag, input logic ordy);
    bus32.in_valid = v;    bus64.in_valid = v;
    bus32.in_instr = instr; bus64.in_instr = instr;
    bus32.in_imm_src = src; bus64.in_imm_src = src;
    bus32.in_pc = pc[31:0]; bus64.in_pc = pc;
    bus32.in_tag = tag;    bus64.in_tag = tag;
    bus32.out_ready = ordy; bus64.out_ready = ordy;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{32'hFFF00093, 3'b001, 64'h0,        5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 3'b100, 64'h100,      5'd2, 32'hFFFFFFFC, 32'h000000FC,
                64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0};
    vecs[2] = '{32'h123450B7, 3'b000, 64'h1000,     5'd3, 32'h12345000, 32'h12346000,
                64'h12345000, 64'h12346000, 1'b0};
    vecs[3] = '{32'h000FD073, 3'b101, 64'h0,        5'd4, 32'h1F, 32'h1F, 64'h1F, 64'h1F, 1'b0};
    vecs[4] = '{32'h03F01013, 3'b110, 64'h10,       5'd5, 32'h1F, 32'h2F, 64'h3F, 64'h4F, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 3'b111, 64'h20,       5'd6, 32'h0, 32'h20, 64'h0, 64'h20, 1'b1};
    vecs[6] = '{32'h0080006F, 3'b010, 64'h40,       5'd7, 32'h8, 32'h48, 64'h8, 64'h48, 1'b0};
    vecs[7] = '{32'hFE000E23, 3'b011, 64'h200,      5'd8, 32'hFFFFFFFC, 32'h1FC,
                64'hFFFFFFFFFFFFFFFC, 64'h1FC, 1'b0};
    vecs[8] = '{32'h7FF00093, 3'b001, 64'hFFFFFFF0, 5'd9, 32'h7FF, 32'h7EF,
                64'h7FF, 64'h1000007EF, 1'b0};
    vecs[9] = '{32'h800000B7, 3'b000, 64'h0,        5'd10, 32'h80000000, 32'h80000000,
                64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};

    // Reset state
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b0);
    step();
    step();
    check("rst_in_ready32", {63'b0, bus32.in_ready}, 64'd1);
    check("rst_out_valid32", {63'b0, bus32.out_valid}, 64'd0);
    check("rst_out_imm32", {32'b0, bus32.out_imm}, 64'd0);
    check("rst_out_pc_rel32", {32'b0, bus32.out_pc_rel}, 64'd0);
    check("rst_out_tag32", {59'b0, bus32.out_tag}, 64'd0);
    check("rst_in_ready64", {63'b0, bus64.in_ready}, 64'd1);
    check("rst_out_imm64", bus64.out_imm, 64'd0);
    check("rst_out_err64", {63'b0, bus64.out_imm_err}, 64'd0);
    rst = 1'b0;
    step();

    // Table-driven decode vectors, one beat at a time from an empty FIFO
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].src, vecs[i].pc, vecs[i].tag, 1'b1);
      #1;
      check($sformatf("v%0d_no_bypass", i), {63'b0, bus32.out_valid}, 64'd0);
      step();
      drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b1);
      check($sformatf("v%0d_valid32", i), {63'b0, bus32.out_valid}, 64'd1);
      check($sformatf("v%0d_imm32", i), {32'b0, bus32.out_imm}, {32'b0, vecs[i].imm32});
      check($sformatf("v%0d_rel32", i), {32'b0, bus32.out_pc_rel}, {32'b0, vecs[i].rel32});
      check($sformatf("v%0d_pc32", i), {32'b0, bus32.out_pc}, {32'b0, vecs[i].pc[31:0]});
      check($sformatf("v%0d_tag32", i), {59'b0, bus32.out_tag}, {59'b0, vecs[i].tag});
      check($sformatf("v%0d_err32", i), {63'b0, bus32.out_imm_err}, {63'b0, vecs[i].err});
      check($sformatf("v%0d_valid64", i), {63'b0, bus64.out_valid}, 64'd1);
      check($sformatf("v%0d_imm64", i), bus64.out_imm, vecs[i].imm64);
      check($sformatf("v%0d_rel64", i), bus64.out_pc_rel, vecs[i].rel64);
      check($sformatf("v%0d_err64", i), {63'b0, bus64.out_imm_err}, {63'b0, vecs[i].err});
      step();
      check($sformatf("v%0d_drained", i), {63'b0, bus32.out_valid}, 64'd0);
    end

    // Backpressure: tags 1,2 fill the FIFO, tag 3 is held off
    drive(1'b1, 32'hFFF00093, 3'b001, 64'h0, 5'd1, 1'b0);
    step();
    drive(1'b1, 32'hFFF00093, 3'b001, 64'h4, 5'd2, 1'b0);
    step();
    drive(1'b1, 32'hFFF00093, 3'b001, 64'h8, 5'd3, 1'b0);
    check("bp_full_in_ready", {63'b0, bus32.in_ready}, 64'd0);
    step();
    check("bp_hold_in_ready", {63'b0, bus32.in_ready}, 64'd0);
    check("bp_head_tag1", {59'b0, bus32.out_tag}, 64'd1);
    check("bp_head_tag1_64", {59'b0, bus64.out_tag}, 64'd1);
    bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
    step();
    check("bp_head_tag2", {59'b0, bus32.out_tag}, 64'd2);
    check("bp_ready_again", {63'b0, bus32.in_ready}, 64'd1);
    step();
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b1);
    check("bp_head_tag3", {59'b0, bus32.out_tag}, 64'd3);
    check("bp_head_valid3", {63'b0, bus32.out_valid}, 64'd1);
    check("bp_tag3_pc", {32'b0, bus32.out_pc}, 64'h8);
    step();
    check("bp_drained", {63'b0, bus32.out_valid}, 64'd0);

    // Simultaneous accept and pop at count=1 for 10 cycles
    drive(1'b1, 32'h00100093, 3'b001, 64'h0, 5'd10, 1'b1);
    step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h00100093, 3'b001, 64'(k), 5'(11 + k), 1'b1);
      step();
      check($sformatf("sim%0d_valid", k), {63'b0, bus32.out_valid}, 64'd1);
      check($sformatf("sim%0d_tag", k), {59'b0, bus32.out_tag}, 64'(11 + k));
      check($sformatf("sim%0d_in_ready", k), {63'b0, bus32.in_ready}, 64'd1);
    end
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b1);
    step();
    check("sim_drained", {63'b0, bus32.out_valid}, 64'd0);

    // Flush with count=2
    drive(1'b1, 32'hFFFFFFFF, 3'b111, 64'h0, 5'd20, 1'b0);
    step();
    step();
    check("fl_full", {63'b0, bus32.in_ready}, 64'd0);
    check("fl_illegal_err", {63'b0, bus32.out_imm_err}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b0);
    check("fl_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("fl_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    check("fl_out_valid64", {63'b0, bus64.out_valid}, 64'd0);

    // Beat offered in a flush cycle at count=0 is dropped
    drive(1'b1, 32'h00100093, 3'b001, 64'h0, 5'd21, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b0);
    check("fl_drop_beat", {63'b0, bus32.out_valid}, 64'd0);
    step();
    check("fl_drop_beat_later", {63'b0, bus32.out_valid}, 64'd0);

    // Asynchronous reset mid-cycle with count=1
    drive(1'b1, 32'h123450B7, 3'b000, 64'h30, 5'd22, 1'b0);
    step();
    drive(1'b0, 32'h0, 3'b000, 64'h0, 5'd0, 1'b0);
    check("ar_loaded", {63'b0, bus32.out_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("ar_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    check("ar_out_imm", {32'b0, bus32.out_imm}, 64'd0);
    check("ar_out_tag", {59'b0, bus32.out_tag}, 64'd0);
    check("ar_out_pc64", bus64.out_pc, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("ar_post_valid", {63'b0, bus32.out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
